// File: rtl/spi_xfer_master_pkg.sv
// Shared constants and helpers for spi_xfer_master.
// Holds the SPI core register map and CTRL bit positions, kept identical to the core's
// spi_defines.v (SPI_TX_0, SPI_RX_0, SPI_CTRL, SPI_DEVIDE, SPI_SS, SPI_CTRL_*), plus small
// functions that build the CTRL word and the RX length mask.
package spi_xfer_master_pkg;

  // Register byte offsets inside the SPI core
  localparam logic [4:0] SPI_TX_0   = 5'h00;
  localparam logic [4:0] SPI_RX_0   = 5'h00;
  localparam logic [4:0] SPI_CTRL   = 5'h10;
  localparam logic [4:0] SPI_DEVIDE = 5'h14;
  localparam logic [4:0] SPI_SS     = 5'h18;

  // CTRL register bit indices
  localparam int unsigned SPI_CTRL_ASS        = 13;
  localparam int unsigned SPI_CTRL_IE         = 12;
  localparam int unsigned SPI_CTRL_LSB        = 11;
  localparam int unsigned SPI_CTRL_TX_NEGEDGE = 10;
  localparam int unsigned SPI_CTRL_RX_NEGEDGE = 9;
  localparam int unsigned SPI_CTRL_GO         = 8;

  // A command length of 0 means a full 32-bit character
  function automatic logic [6:0] char_len(input logic [4:0] len);
    return (len == 5'd0) ? 7'd32 : {2'b00, len};
  endfunction

  function automatic logic [31:0] len_mask(input logic [4:0] len);
    return (len == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
  endfunction

  // mode = {LSB, TX_NEGEDGE, RX_NEGEDGE}; ASS and GO are always set
  function automatic logic [31:0] ctrl_word(input logic [4:0] len, input logic [2:0] mode,
                                            input logic ie);
    logic [31:0] w;
    w                      = '0;
    w[SPI_CTRL_ASS]        = 1'b1;
    w[SPI_CTRL_IE]         = ie;
    w[SPI_CTRL_LSB]        = mode[2];
    w[SPI_CTRL_TX_NEGEDGE] = mode[1];
    w[SPI_CTRL_RX_NEGEDGE] = mode[0];
    w[SPI_CTRL_GO]         = 1'b1;
    w[6:0]                 = char_len(len);
    return w;
  endfunction

endpackage

// File: rtl/spi_xfer_master_wbm_port.sv
// spi_wbm_port: single-access Wishbone master engine.
// Holds one access at a time. A request (i_req level) starts an access when the engine is idle;
// stb/cyc rise together with adr/dat/we and stay up until the ack cycle, then drop on that edge.
// o_done pulses for one cycle after the ack with the read data in o_rdat; that cycle is also the
// mandatory idle cycle, so a request still held during it is not started.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   i_req/i_we/i_adr/i_wdat     access request
//   o_done/o_rdat               completion pulse and registered read data
//   o_wbm_*/i_wbm_*             Wishbone master signals
module spi_wbm_port (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_adr,
  input  logic [31:0] i_wdat,
  output logic        o_done,
  output logic [31:0] o_rdat,
  output logic [4:0]  o_wbm_adr,
  output logic [31:0] o_wbm_dat,
  output logic [3:0]  o_wbm_sel,
  output logic        o_wbm_we,
  output logic        o_wbm_cyc,
  output logic        o_wbm_stb,
  input  logic [31:0] i_wbm_dat,
  input  logic        i_wbm_ack
);

  logic        r_stb;
  logic        r_we;
  logic [4:0]  r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_done;
  logic [31:0] r_rdat;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_stb  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_done <= 1'b0;
      r_rdat <= '0;
    end else begin
      r_sel  <= 4'hF;
      r_done <= 1'b0;
      if (r_stb) begin
        if (i_wbm_ack) begin
          r_stb  <= 1'b0;
          r_done <= 1'b1;
          r_rdat <= i_wbm_dat;
        end
      end else if (i_req && !r_done) begin
        // r_done high marks the idle cycle after an ack
        r_stb <= 1'b1;
        r_we  <= i_we;
        r_adr <= i_adr;
        r_dat <= i_wdat;
      end
    end
  end

  assign o_done    = r_done;
  assign o_rdat    = r_rdat;
  assign o_wbm_adr = r_adr;
  assign o_wbm_dat = r_dat;
  assign o_wbm_sel = r_sel;
  assign o_wbm_we  = r_we;
  assign o_wbm_cyc = r_stb;
  assign o_wbm_stb = r_stb;

endmodule

// File: rtl/spi_xfer_master.sv
// spi_xfer_master: Wishbone sequencer driving the SPI core register file.
// After reset it writes DIVIDE once, then per command writes SS (only when the mask changed or
// the cached mask is invalid), TX0, CTRL with GO, waits for completion, reads RX0 and returns the
// masked word on a valid/ready response port. A wait that runs out of POLL_LIMIT returns
// rsp_err_o=1 with zero data and invalidates the SS cache.
// Build option: define SPI_XFER_IRQ_EN to wait on wbm_int_i (POLL_LIMIT then counts cycles)
// instead of polling CTRL.GO (POLL_LIMIT counts CTRL reads).
// Ports:
//   wb_clk_i, wb_rst_i                       clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o/cmd_data_i/
//   cmd_len_i/cmd_ss_i                       command stream
//   rsp_valid_o/rsp_ready_i/rsp_data_o/
//   rsp_err_o                                response stream
//   busy_o                                   high outside READY
//   wbm_*                                    Wishbone master towards the SPI core
module spi_xfer_master
  import spi_xfer_master_pkg::*;
#(
  parameter logic [15:0]  DIVIDER_INIT = 16'd1,
  parameter logic [2:0]   CTRL_MODE    = 3'b000,
  parameter int unsigned  POLL_LIMIT   = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_data_i,
  input  logic [4:0]  cmd_len_i,
  input  logic [7:0]  cmd_ss_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [4:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_int_i
);

  typedef enum logic [2:0] {
    StInitDiv, StReady, StWrSs, StWrTx, StWrCtrl, StWait, StRdRx, StResp
  } state_e;

  // Counter holds 0..POLL_LIMIT-1; the last value ends the wait
  localparam int unsigned    CntW     = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT);
  localparam logic [CntW-1:0] PollLast = CntW'(POLL_LIMIT - 1);

  state_e      r_state, w_state_next;
  logic        r_cmd_ready, r_busy, r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_data;
  logic [31:0] r_data;
  logic [4:0]  r_len;
  logic [7:0]  r_ss;
  logic [7:0]  r_ss_cache;
  logic        r_ss_vld;
  logic [CntW-1:0] r_poll_cnt;

  logic        w_req, w_we, w_done;
  logic [4:0]  w_adr;
  logic [31:0] w_wdat, w_rdat;
  logic        w_wait_step, w_wait_ok, w_timeout;
  logic        w_ie;

`ifdef SPI_XFER_IRQ_EN
  assign w_ie        = 1'b1;
  assign w_wait_step = 1'b1;                 // one step per clock cycle
  assign w_wait_ok   = wbm_int_i;
`else
  logic w_unused;
  assign w_unused    = wbm_int_i;
  assign w_ie        = 1'b0;
  assign w_wait_step = w_done;               // one step per completed CTRL read
  assign w_wait_ok   = ~w_rdat[SPI_CTRL_GO];
`endif

  assign w_timeout = (r_state == StWait) && w_wait_step && !w_wait_ok &&
                     (r_poll_cnt == PollLast);

  // State register and registered handshake outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= StInitDiv;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_ready <= (w_state_next == StReady);
      r_busy      <= (w_state_next != StReady);
      r_rsp_valid <= (w_state_next == StResp);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInitDiv: if (w_done) w_state_next = StReady;
      StReady: begin
        if (cmd_valid_i) begin
          w_state_next = (r_ss_vld && (cmd_ss_i == r_ss_cache)) ? StWrTx : StWrSs;
        end
      end
      StWrSs:   if (w_done) w_state_next = StWrTx;
      StWrTx:   if (w_done) w_state_next = StWrCtrl;
      StWrCtrl: if (w_done) w_state_next = StWait;
      StWait: begin
        if (w_wait_step) begin
          if (w_wait_ok)      w_state_next = StRdRx;
          else if (w_timeout) w_state_next = StResp;
        end
      end
      StRdRx:   if (w_done) w_state_next = StResp;
      StResp:   if (rsp_ready_i) w_state_next = StReady;
      default:  w_state_next = StInitDiv;
    endcase
  end

  // Wishbone request decode; the port holds off while its done pulse is up
  always_comb begin
    w_req  = 1'b0;
    w_we   = 1'b0;
    w_adr  = '0;
    w_wdat = '0;
    unique case (r_state)
      StInitDiv: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = SPI_DEVIDE; w_wdat = {16'h0000, DIVIDER_INIT};
      end
      StWrSs: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = SPI_SS; w_wdat = {24'h000000, r_ss};
      end
      StWrTx: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = SPI_TX_0; w_wdat = r_data;
      end
      StWrCtrl: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = SPI_CTRL; w_wdat = ctrl_word(r_len, CTRL_MODE, w_ie);
      end
      StWait: begin
`ifndef SPI_XFER_IRQ_EN
        w_req = 1'b1; w_adr = SPI_CTRL;
`endif
      end
      StRdRx: begin
        w_req = 1'b1; w_adr = SPI_RX_0;
      end
      default: ;
    endcase
  end

  // Command latch, SS cache, poll counter and response registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_data     <= '0;
      r_len      <= '0;
      r_ss       <= '0;
      r_ss_cache <= '0;
      r_ss_vld   <= 1'b0;
      r_poll_cnt <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (r_state == StReady && cmd_valid_i) begin
        r_data <= cmd_data_i;
        r_len  <= cmd_len_i;
        r_ss   <= cmd_ss_i;
      end
      if (r_state == StWrSs && w_done) begin
        r_ss_cache <= r_ss;
        r_ss_vld   <= 1'b1;
      end
      if (r_state == StWrCtrl) begin
        r_poll_cnt <= '0;
      end else if (r_state == StWait && w_wait_step && !w_wait_ok && !w_timeout) begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end
      if (w_timeout) begin
        // Core state is unknown after a timeout, so force an SS rewrite next time
        r_ss_vld   <= 1'b0;
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end else if (r_state == StRdRx && w_done) begin
        r_rsp_data <= w_rdat & len_mask(r_len);
        r_rsp_err  <= 1'b0;
      end
    end
  end

  spi_wbm_port u_port (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .i_req     (w_req),
    .i_we      (w_we),
    .i_adr     (w_adr),
    .i_wdat    (w_wdat),
    .o_done    (w_done),
    .o_rdat    (w_rdat),
    .o_wbm_adr (wbm_adr_o),
    .o_wbm_dat (wbm_dat_o),
    .o_wbm_sel (wbm_sel_o),
    .o_wbm_we  (wbm_we_o),
    .o_wbm_cyc (wbm_cyc_o),
    .o_wbm_stb (wbm_stb_o),
    .i_wbm_dat (wbm_dat_i),
    .i_wbm_ack (wbm_ack_i)
  );

  assign cmd_ready_o = r_cmd_ready;
  assign busy_o      = r_busy;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;

endmodule
